sr_muldiv_unit: RTL

Parametrised multiply/divide unit for the multi-cycle schoolRISCV core, covering the full RV32M operation set. It replaces the fixed-latency multiplier-only MDU. Adds:
- configurable datapath width and multiplier latency;
- an iterative radix-2 divider;
- a ready/valid input handshake and abort.

The control FSM drives it from the execute state. It sits beside the ALU, fed by the srcA/srcB operand muxes; its result goes to the register-file write-data mux.

---
 rtl/sr_muldiv_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sr_muldiv_unit.sv
// sr_muldiv_unit: RV32M multiply/divide unit for the multi-cycle schoolRISCV core.
// Multiply uses a registered delay counter of MUL_LATENCY stages; divide is an
// iterative radix-2 restoring divider working on operand magnitudes.
// Build macro MDU_DIV_EN: when defined, the divider and the special-case path
// are built; when undefined, every divide/remainder op completes in one cycle
// with result 0 and illegal=1.
module sr_muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       op,
  input  logic             src_vld,
  output logic             src_rdy,
  input  logic             src_clear,
  output logic [WIDTH-1:0] result,
  output logic             result_vld,
  output logic             illegal
);

  localparam int unsigned MAX_CNT = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT =
    CNT_W'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             result_vld_q;
  logic             illegal_q;

  // Multiply datapath: sign-extend to 2*WIDTH per funct3 and pick the half
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [1:0]         mul_op;
  logic [2*WIDTH-1:0] mul_ext_a;
  logic [2*WIDTH-1:0] mul_ext_b;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_res;

  always_comb begin
    // With a single-cycle latency the product is taken straight from the
    // operand inputs on the accept edge; otherwise from the captured copies.
    if (MUL_LATENCY == 1) begin
      mul_a  = srcA;
      mul_b  = srcB;
      mul_op = op[1:0];
    end else begin
      mul_a  = a_q;
      mul_b  = b_q;
      mul_op = op_q;
    end
    mul_ext_a = {{WIDTH{(mul_op != 2'b11) & mul_a[WIDTH-1]}}, mul_a};
    mul_ext_b = {{WIDTH{(mul_op == 2'b01) & mul_b[WIDTH-1]}}, mul_b};
    mul_prod  = mul_ext_a * mul_ext_b;
    mul_res   = (mul_op == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
  end

`ifdef MDU_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             want_rem_q;

  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] div_res;

  // Divide datapath: operand magnitudes, special cases and one restoring step
  always_comb begin
    sgn_in   = ~op[0];
    a_neg    = sgn_in & srcA[WIDTH-1];
    b_neg    = sgn_in & srcB[WIDTH-1];
    abs_a    = a_neg ? (~srcA + 1'b1) : srcA;
    abs_b    = b_neg ? (~srcB + 1'b1) : srcB;
    div_zero = (srcB == '0);
    div_ovf  = sgn_in && (srcA == MOST_NEG) && (srcB == '1);
    if (div_zero) begin
      special_res = op[1] ? srcA : '1;
    end else begin
      special_res = op[1] ? '0 : srcA;
    end

    trial = {rem_q, quo_q[WIDTH-1]};
    ge    = (trial >= {1'b0, dvs_q});
    rem_d = ge ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], ge};

    // Sign fix folded into the final iteration's write so the result lands
    // WIDTH+1 cycles after accept.
    if (want_rem_q) begin
      div_res = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
    end else begin
      div_res = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
    end
  end
`endif

  // Control FSM with registered result, result_vld and illegal
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      illegal_q    <= 1'b0;
`ifdef MDU_DIV_EN
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      want_rem_q   <= 1'b0;
`endif
    end else begin
      result_vld_q <= 1'b0;
      if (src_clear) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (src_vld) begin
              a_q  <= srcA;
              b_q  <= srcB;
              op_q <= op[1:0];
              if (!op[2]) begin
                if (MUL_LATENCY == 1) begin
                  result_q     <= mul_res;
                  illegal_q    <= 1'b0;
                  result_vld_q <= 1'b1;
                end else begin
                  state_q <= S_MUL;
                  cnt_q   <= MUL_CNT_INIT;
                end
              end else begin
                // The FIX outcome is resolved on the accept edge itself so it
                // is reported in cycle 1 with the FSM already back in IDLE.
`ifdef MDU_DIV_EN
                if (div_zero || div_ovf) begin
                  result_q     <= special_res;
                  illegal_q    <= 1'b0;
                  result_vld_q <= 1'b1;
                end else begin
                  state_q    <= S_DIV;
                  cnt_q      <= CNT_W'(WIDTH - 1);
                  rem_q      <= '0;
                  quo_q      <= abs_a;
                  dvs_q      <= abs_b;
                  neg_quo_q  <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  want_rem_q <= op[1];
                end
`else
                result_q     <= '0;
                illegal_q    <= 1'b1;
                result_vld_q <= 1'b1;
`endif
              end
            end
          end
          S_MUL: begin
            if (cnt_q == '0) begin
              result_q     <= mul_res;
              illegal_q    <= 1'b0;
              result_vld_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`ifdef MDU_DIV_EN
          S_DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) begin
              result_q     <= div_res;
              illegal_q    <= 1'b0;
              result_vld_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign src_rdy    = (state_q == S_IDLE);
  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign illegal    = illegal_q;

endmodule
